immediate_decoder_pipe: RTL

//  Elastic, pipelined immediate generator for the RISC-V core.
//  - Takes a full 32-bit instruction word and auto-decodes its format from the opcode.
//  - Supports an optional forced format.
//  - Emits the sign/zero-extended immediate at XLEN bits, together with the format and an illegal flag.
//  - Sits between fetch and the register-read/ALU stages, with a valid/ready handshake on both sides.

---
 rtl/immediate_decoder_pipe.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/immediate_decoder_pipe.sv
// immediate_decoder_pipe
//   Elastic, pipelined immediate generator sitting between fetch and the
//   register-read/ALU stages. The instruction format is decoded from the
//   opcode, unless the caller forces a format. The immediate is extracted,
//   extended to XLEN bits, and pushed through PIPE_DEPTH register stages.
//   Each stage has valid/ready flow control, so the block sustains one beat
//   per cycle and holds its outputs stable while stalled.
//
// Parameters
//   XLEN        output immediate width, 32 or 64
//   PIPE_DEPTH  number of register stages (1..4); latency in cycles
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset; flushes every stage
//   in_valid      input beat present
//   in_ready      block accepts a beat this cycle (0 while rst=1)
//   in_instr      raw 32-bit instruction word
//   in_fmt_force  1: use in_fmt instead of the opcode decode
//   in_fmt        forced format code
//   out_valid     output beat present
//   out_ready     downstream accepts the beat
//   out_imm       extended immediate
//   out_fmt       0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
//   out_illegal   opcode not recognised (auto-decode mode only)

module immediate_decoder_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            in_fmt_force,
  input  logic [2:0]      in_fmt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ---------------------------------------------------------------------
  // Decode (combinational, in front of stage 0)
  // ---------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  fmt_e            auto_fmt;
  logic            auto_illegal;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_shamt;
  logic [XLEN-1:0] imm_zimm;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  always_comb begin
    auto_fmt     = FMT_NONE;
    auto_illegal = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          auto_fmt = FMT_SHAMT;
        end else begin
          auto_fmt = FMT_I;
        end
      end
      OP_LOAD, OP_JALR: auto_fmt = FMT_I;
      OP_SYSTEM:        auto_fmt = funct3[2] ? FMT_ZIMM : FMT_I;
      OP_STORE:         auto_fmt = FMT_S;
      OP_BRANCH:        auto_fmt = FMT_B;
      OP_LUI, OP_AUIPC: auto_fmt = FMT_U;
      OP_JAL:           auto_fmt = FMT_J;
      OP_REG, OP_REG32: auto_fmt = FMT_NONE;
      default: begin
        auto_fmt     = FMT_NONE;
        auto_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    dec_fmt     = auto_fmt;
    dec_illegal = auto_illegal;
    if (in_fmt_force) begin
      dec_fmt     = fmt_e'(in_fmt);
      dec_illegal = 1'b0;
    end
  end

  // Size casts of signed operands sign-extend from instr[31] at any XLEN.
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0}));
  assign imm_shamt = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
  assign imm_zimm  = XLEN'(in_instr[19:15]);

  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FMT_I:     dec_imm = imm_i;
      FMT_S:     dec_imm = imm_s;
      FMT_B:     dec_imm = imm_b;
      FMT_U:     dec_imm = imm_u;
      FMT_J:     dec_imm = imm_j;
      FMT_SHAMT: dec_imm = imm_shamt;
      FMT_ZIMM:  dec_imm = imm_zimm;
      default:   dec_imm = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Elastic pipeline
  // ---------------------------------------------------------------------
  logic [PIPE_DEPTH:0]   ready;
  logic [PIPE_DEPTH-1:0] stg_valid;
  logic [PIPE_DEPTH-1:0] stg_illegal;
  logic [XLEN-1:0]       stg_imm [PIPE_DEPTH];
  fmt_e                  stg_fmt [PIPE_DEPTH];

  assign ready[PIPE_DEPTH] = out_ready;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    logic            up_valid;
    logic [XLEN-1:0] up_imm;
    fmt_e            up_fmt;
    logic            up_illegal;

    logic            valid_q;
    logic [XLEN-1:0] imm_q;
    fmt_e            fmt_q;
    logic            illegal_q;

    if (k == 0) begin : g_head
      assign up_valid   = in_valid;
      assign up_imm     = dec_imm;
      assign up_fmt     = dec_fmt;
      assign up_illegal = dec_illegal;
    end else begin : g_body
      assign up_valid   = stg_valid[k-1];
      assign up_imm     = stg_imm[k-1];
      assign up_fmt     = stg_fmt[k-1];
      assign up_illegal = stg_illegal[k-1];
    end

    // A stage may load whenever it is empty or its own content moves on
    // this cycle, so bubbles collapse and a full pipe still streams.
    assign ready[k] = !valid_q | ready[k+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q   <= 1'b0;
        imm_q     <= '0;
        fmt_q     <= FMT_NONE;
        illegal_q <= 1'b0;
      end else if (ready[k]) begin
        valid_q <= up_valid;
        // Payload only follows real beats; idle input never disturbs it.
        if (up_valid) begin
          imm_q     <= up_imm;
          fmt_q     <= up_fmt;
          illegal_q <= up_illegal;
        end
      end
    end

    assign stg_valid[k]   = valid_q;
    assign stg_imm[k]     = imm_q;
    assign stg_fmt[k]     = fmt_q;
    assign stg_illegal[k] = illegal_q;
  end

  assign in_ready    = ready[0] & ~rst;
  assign out_valid   = stg_valid[PIPE_DEPTH-1];
  assign out_imm     = stg_imm[PIPE_DEPTH-1];
  assign out_fmt     = stg_fmt[PIPE_DEPTH-1];
  assign out_illegal = stg_illegal[PIPE_DEPTH-1];

endmodule
